// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
//   - state_e       : controller FSM states
//   - *Def          : default width/depth constants
//   - ConflictCntW  : width of the optional same-address write conflict counter
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StFinish
  } state_e;

  localparam int unsigned NumCoresDef  = 4;
  localparam int unsigned DataWDef     = 12;
  localparam int unsigned AddrWDef     = 12;
  localparam int unsigned DepthDef     = 256;
  localparam int unsigned ConflictCntW = 16;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage for the data memory controller.
// Ports:
//   clk, rstN      : clock; async active-low reset (host read register only, storage not reset)
//   rd_addr/rd_data: NUM_CORES combinational read ports, out-of-range reads return 0
//   host_rd_en/host_rd_addr/host_rd_data : registered host read port
//   wr_en/wr_addr/wr_data : NUM_CORES+1 write ports; lowest index wins on same address,
//                           out-of-range writes are dropped
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned NUM_CORES = NumCoresDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned ADDR_W    = AddrWDef,
  parameter int unsigned DEPTH     = DepthDef
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic [NUM_CORES*ADDR_W-1:0]     rd_addr,
  output logic [NUM_CORES*DATA_W-1:0]     rd_data,
  input  logic                            host_rd_en,
  input  logic [ADDR_W-1:0]               host_rd_addr,
  output logic [DATA_W-1:0]               host_rd_data,
  input  logic [NUM_CORES:0]              wr_en,
  input  logic [(NUM_CORES+1)*ADDR_W-1:0] wr_addr,
  input  logic [(NUM_CORES+1)*DATA_W-1:0] wr_data
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(logic [ADDR_W-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (in_range(rd_addr[i*ADDR_W +: ADDR_W])) begin
        rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: IdxW]];
      end
    end
  end

  // Walk ports from highest to lowest so the lowest index is the last assignment and wins.
  always_ff @(posedge clk) begin
    for (int i = int'(NUM_CORES); i >= 0; i--) begin
      if (wr_en[i] && in_range(wr_addr[i*ADDR_W +: ADDR_W])) begin
        mem[wr_addr[i*ADDR_W +: IdxW]] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      host_rd_data <= '0;
    end else if (host_rd_en) begin
      host_rd_data <= in_range(host_rd_addr) ? mem[host_rd_addr[IdxW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Shared data memory and launch controller for the multicore array.
// Host side: req/wr/addr/wdata in, rdata/ack out (access only while idle), start in,
//            busy/finish out.
// Core side: per-core addr/wdata/wrEn in, combinational rdata out, start pulse out,
//            per-core done levels in.
// Optional: define DMEM_CONFLICT_CNT_EN to add conflict_cnt, a saturating count of cycles
//           in which two or more cores write the same in-range address.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned NUM_CORES = NumCoresDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned ADDR_W    = AddrWDef,
  parameter int unsigned DEPTH     = DepthDef
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        host_req,
  input  logic                        host_wr,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic [DATA_W-1:0]           host_rdata,
  output logic                        host_ack,
  input  logic                        host_start,
  output logic                        host_busy,
  output logic                        host_finish,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_wrEn,
  output logic [NUM_CORES*DATA_W-1:0] core_rdata,
  output logic                        core_start,
  input  logic [NUM_CORES-1:0]        core_done
`ifdef DMEM_CONFLICT_CNT_EN
  ,
  output logic [ConflictCntW-1:0]     conflict_cnt
`endif
);

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] done_seen_q, done_seen_d;
  logic                 host_ack_q;
  logic                 host_issue;
  logic                 core_phase;
  logic [NUM_CORES-1:0] core_wr_en;

  always_comb begin
    state_d     = state_q;
    done_seen_d = done_seen_q;
    unique case (state_q)
      StIdle: begin
        if (host_start) state_d = StStart;
      end
      StStart: begin
        done_seen_d = '0;
        state_d     = StRun;
      end
      StRun: begin
        done_seen_d = done_seen_q | core_done;
        if (&done_seen_q) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StIdle;
      done_seen_q <= '0;
      host_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_seen_q <= done_seen_d;
      host_ack_q  <= host_issue;
    end
  end

  // Cores own the memory from the start pulse until the finish cycle.
  assign core_phase  = (state_q == StStart) || (state_q == StRun);
  assign core_start  = (state_q == StStart);
  assign host_busy   = core_phase;
  assign host_finish = (state_q == StFinish);
  assign core_wr_en  = core_wrEn & {NUM_CORES{core_phase}};

  // A launch request in the same idle cycle takes precedence over a host access.
  assign host_issue = (state_q == StIdle) && !host_start && host_req && !host_ack_q;
  assign host_ack   = host_ack_q;

  dmem_array #(
    .NUM_CORES(NUM_CORES),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH)
  ) u_array (
    .clk         (clk),
    .rstN        (rstN),
    .rd_addr     (core_addr),
    .rd_data     (core_rdata),
    .host_rd_en  (host_issue && !host_wr),
    .host_rd_addr(host_addr),
    .host_rd_data(host_rdata),
    .wr_en       ({host_issue && host_wr, core_wr_en}),
    .wr_addr     ({host_addr, core_addr}),
    .wr_data     ({host_wdata, core_wdata})
  );

`ifdef DMEM_CONFLICT_CNT_EN
  logic                    conflict;
  logic [ConflictCntW-1:0] conflict_cnt_q;

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      for (int j = i + 1; j < int'(NUM_CORES); j++) begin
        if (core_wr_en[i] && core_wr_en[j] &&
            (core_addr[i*ADDR_W +: ADDR_W] == core_addr[j*ADDR_W +: ADDR_W]) &&
            (32'(core_addr[i*ADDR_W +: ADDR_W]) < DEPTH)) begin
          conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      conflict_cnt_q <= '0;
    end else if (state_q == StStart) begin
      conflict_cnt_q <= '0;
    end else if (conflict && (conflict_cnt_q != '1)) begin
      conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
